// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, flush and EX-forwarding control for the 5-stage RV32I pipeline.
// Optional performance counters are built when HAZARD_CTRL_PERF_EN is defined.
package hazard_ctrl_pkg;
  localparam int unsigned OP_W  = 7;
  localparam int unsigned REG_W = 5;

  localparam logic [OP_W-1:0] OP_NOP    = 7'b0000000;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R_TYPE = 7'b0110011;
  localparam logic [OP_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             writes_rd;
    logic             uses_rs1;
    logic             uses_rs2;
    logic             is_load;
    logic             is_mem;
  } stage_t;
endpackage

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned XLEN_CNT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [OP_W-1:0]  id_opcode,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             ex_redirect,
  input  logic             dmem_ready,
  output logic             hold_fe,
  output logic             hold_be,
  output logic             bubble_ex,
  output logic             flush_ifid,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [XLEN_CNT-1:0] perf_stall_cycles,
  output logic [XLEN_CNT-1:0] perf_flushes
`endif
);

  stage_t id_dec;
  stage_t ex_q, mem_q, wb_q;
  stage_t ex_d, mem_d, wb_d;
  logic   memwait, redirect, loaduse;

  // Operand/result usage of the ID instruction; x0 is never a destination.
  always_comb begin : decode
    id_dec       = '0;
    id_dec.valid = id_valid;
    id_dec.rd    = id_rd;
    id_dec.rs1   = id_rs1;
    id_dec.rs2   = id_rs2;
    case (id_opcode)
      OP_LOAD:   begin id_dec.writes_rd = 1'b1; id_dec.uses_rs1 = 1'b1;
                       id_dec.is_load = 1'b1; id_dec.is_mem = 1'b1; end
      OP_STORE:  begin id_dec.uses_rs1 = 1'b1; id_dec.uses_rs2 = 1'b1; id_dec.is_mem = 1'b1; end
      OP_R_TYPE: begin id_dec.writes_rd = 1'b1; id_dec.uses_rs1 = 1'b1; id_dec.uses_rs2 = 1'b1; end
      OP_IMM:    begin id_dec.writes_rd = 1'b1; id_dec.uses_rs1 = 1'b1; end
      OP_LUI, OP_AUIPC, OP_JAL: id_dec.writes_rd = 1'b1;
      OP_JALR:   begin id_dec.writes_rd = 1'b1; id_dec.uses_rs1 = 1'b1; end
      OP_BRANCH: begin id_dec.uses_rs1 = 1'b1; id_dec.uses_rs2 = 1'b1; end
      default:   ;
    endcase
    id_dec.writes_rd = id_dec.writes_rd & (id_rd != '0);
  end

  assign memwait  = mem_q.valid & mem_q.is_mem & ~dmem_ready;
  assign redirect = ex_redirect;
  assign loaduse  = id_valid & ex_q.valid & ex_q.is_load & ex_q.writes_rd &
                    ((id_dec.uses_rs1 & (id_rs1 == ex_q.rd)) |
                     (id_dec.uses_rs2 & (id_rs2 == ex_q.rd)));

  // EX/MEM result beats MEM/WB; a load still in MEM has no result yet.
  function automatic logic [1:0] fwd_sel(input logic uses, input logic [REG_W-1:0] rs,
                                         input stage_t mem, input stage_t wb);
    fwd_sel = 2'b00;
    if (uses) begin
      if (mem.valid && mem.writes_rd && !mem.is_load && (mem.rd == rs)) fwd_sel = 2'b01;
      else if (wb.valid && wb.writes_rd && (wb.rd == rs))                fwd_sel = 2'b10;
    end
  endfunction

  always_comb begin : ctrl
    hold_fe    = 1'b0;
    hold_be    = 1'b0;
    bubble_ex  = 1'b0;
    flush_ifid = 1'b0;
    fwd_a      = 2'b00;
    fwd_b      = 2'b00;
    if (!rst) begin
      if (memwait) begin
        hold_fe = 1'b1;
        hold_be = 1'b1;
      end else if (redirect) begin
        flush_ifid = 1'b1;
        bubble_ex  = 1'b1;
      end else if (loaduse) begin
        hold_fe   = 1'b1;
        bubble_ex = 1'b1;
      end
      fwd_a = fwd_sel(ex_q.uses_rs1, ex_q.rs1, mem_q, wb_q);
      fwd_b = fwd_sel(ex_q.uses_rs2, ex_q.rs2, mem_q, wb_q);
    end
  end

  // Shadow pipeline advance: frozen on a memory wait, bubble inserted on redirect/load-use.
  always_comb begin : shadow_next
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!memwait) begin
      ex_d  = (redirect || loaduse) ? '0 : id_dec;
      mem_d = ex_q;
      wb_d  = mem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flushes      <= '0;
    end else begin
      if (hold_fe)              perf_stall_cycles <= perf_stall_cycles + XLEN_CNT'(1);
      if (!memwait && redirect) perf_flushes      <= perf_flushes + XLEN_CNT'(1);
    end
  end
`else
  // Counter width only matters when the counters are built.
  if (XLEN_CNT == 0) begin : g_no_perf
  end
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RV32I core. It keeps a shadow copy of the destination, source and class information for the EX, MEM and WB stages, and drives the pipeline register hold, bubble and flush controls. It generates the EX-stage operand forwarding selects and stalls the core on load-use hazards and data-memory wait states. It sits beside the datapath, receives the decoded instruction fields from ID, and controls every pipeline register enable.

## Interface
Parameters:
- XLEN_CNT, 32, width of the performance counters (used only with HAZARD_CTRL_PERF_EN).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction (0 = bubble).
- id_opcode  in  7  opcode of the ID instruction, core::OP_Code encoding.
- id_rs1, id_rs2, id_rd  in  5 each  register fields of the ID instruction.
- ex_redirect  in  1  branch taken or JAL/JALR resolved in EX this cycle.
- dmem_ready  in  1  data memory completes the MEM-stage access this cycle.
- hold_fe  out  1  PC and IF/ID register hold.
- hold_be  out  1  ID/EX, EX/MEM and MEM/WB registers hold.
- bubble_ex  out  1  load NOP into ID/EX instead of the ID instruction.
- flush_ifid  out  1  load NOP into IF/ID.
- fwd_a, fwd_b  out  2  EX operand source: 00 regfile/ID/EX, 01 EX/MEM result, 10 MEM/WB result.
- perf_stall_cycles  out  XLEN_CNT  present only with the macro.
- perf_flushes  out  XLEN_CNT  present only with the macro.

## Operation
- Decode of id_opcode:
  - writes_rd: LOAD, R_TYPE, IMM, LUI, AUIPC, JAL, JALR, and only when rd≠0.
  - uses_rs1: LOAD, STORE, R_TYPE, IMM, BRANCH, JALR.
  - uses_rs2: STORE, R_TYPE, BRANCH.
  - is_mem: LOAD, STORE.
  - NOP and unknown opcodes: no reads, no writes.
- Shadow stages ex_q, mem_q, wb_q each hold valid, rd, rs1, rs2, writes_rd, uses_rs1, uses_rs2, is_load, is_mem.
- Condition priority, highest first:
  1. MEMWAIT = mem_q.valid & mem_q.is_mem & !dmem_ready.
     - hold_fe=1, hold_be=1, bubble_ex=0, flush_ifid=0.
     - All shadow stages hold.
     - ex_redirect is ignored; the datapath keeps it stable because ID/EX is frozen.
  2. REDIRECT = ex_redirect.
     - flush_ifid=1, bubble_ex=1, no holds.
     - ex_q←bubble, mem_q←ex_q, wb_q←mem_q.
  3. LOADUSE = id_valid & ex_q.valid & ex_q.is_load & ex_q.writes_rd & ((uses_rs1 & id_rs1==ex_q.rd) | (uses_rs2 & id_rs2==ex_q.rd)).
     - hold_fe=1, bubble_ex=1.
     - ex_q←bubble, mem_q←ex_q, wb_q←mem_q.
  4. RUN.
     - All controls 0.
     - ex_q←ID fields (valid=id_valid), mem_q←ex_q, wb_q←mem_q.
- Forwarding for the EX instruction applies to each of rs1 and rs2 independently, and only when the matching uses flag is set in ex_q:
  - 01 if mem_q.valid & mem_q.writes_rd & !mem_q.is_load & mem_q.rd==ex_q.rsN.
  - Otherwise 10 if wb_q.valid & wb_q.writes_rd & wb_q.rd==ex_q.rsN.
  - Otherwise 00.
  - EX/MEM has priority over MEM/WB. A load in MEM never forwards from 01 (LOADUSE guarantees it is in WB by then).
- Register x0 never matches as a source or destination, because writes_rd is 0 when rd=0.

## Timing
- hold_fe, hold_be, bubble_ex, flush_ifid and fwd_a/b are combinational from the current inputs and the registered shadow state, valid in the same cycle.
- Shadow state and counters update on the rising edge of clk.
- Load-use costs exactly 1 bubble cycle.
- REDIRECT costs 2 killed instructions (IF/ID and ID/EX).
- MEMWAIT lasts as long as dmem_ready=0. The cycle dmem_ready=1 is a normal advance.
- Simultaneous events:
  - REDIRECT and LOADUSE in the same cycle: REDIRECT wins, no hold_fe.
  - MEMWAIT masks both REDIRECT and LOADUSE.
- Reset:
  - While rst=1: all shadow valids←0, counters←0, all outputs forced to 0 (fwd=00).
  - Reset asserted mid-stall takes effect on the next edge.
  - The first cycle after reset is RUN with empty shadow stages.

## Configuration
- HAZARD_CTRL_PERF_EN defined:
  - perf_stall_cycles increments in every cycle with hold_fe=1 and rst=0.
  - perf_flushes increments in every REDIRECT cycle.
  - Both counters wrap modulo 2^XLEN_CNT.
- HAZARD_CTRL_PERF_EN undefined: both ports and counters are absent. Control behaviour is identical.

## Test plan
- ALU back-to-back: ADD x5 (R_TYPE, rd=5) in ID, then next cycle SUB with rs1=5 → one cycle later fwd_a=01, fwd_b=00, no stall.
- Load-use: LOAD rd=7 enters EX while ID holds R_TYPE rs2=7 → hold_fe=1, bubble_ex=1 for exactly 1 cycle; when the consumer reaches EX, fwd_b=10.
- Branch flush: ex_redirect=1 for one cycle → flush_ifid=1, bubble_ex=1 that cycle, ex_q empty next cycle; with macro, perf_flushes 0→1.
- Memory wait: STORE in MEM with dmem_ready=0 for 3 cycles while ex_redirect=1 → hold_fe=hold_be=1 for 3 cycles with flushes 0; cycle 4 performs REDIRECT; with macro, perf_stall_cycles=3.
- x0 and priority: LOAD rd=0 followed by a consumer with rs1=0 → no stall, fwd=00. A write to x3 sitting in both MEM and WB → fwd selects 01.
- Reset mid-MEMWAIT: rst=1 for 1 cycle during a wait → all outputs 0 and counters 0 next cycle, shadow stages empty.
